// File: rtl/bitmanip_iter_shifter_if.sv
// Request/response handshake bundle for the iterative shift/rotate unit.
// master = requester (execute stage), slave = the shifter itself.
interface bitmanip_iter_shifter_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [7:0]      req_shamt;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    modport master (
        output req_valid, req_op, req_rs1, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/bitmanip_iter_shifter.sv
// Multi-cycle SLL/SRL/SRA/SLO/SRO/ROL/ROR unit moving STEP bit positions per busy cycle.
// The interface instance must be built with the same XLEN as this module.
module bitmanip_iter_shifter #(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  flush,
    output logic                  busy,
    bitmanip_iter_shifter_if.slave bus
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_SLO = 3'b011,
        OP_SRO = 3'b100,
        OP_ROL = 3'b101,
        OP_ROR = 3'b110,
        OP_ILL = 3'b111
    } op_e;

    state_e          state_q;
    op_e             op_q;
    logic [XLEN-1:0] work_q;
    logic [SHW-1:0]  rem_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_data_q;
    logic            rsp_err_q;
    logic            busy_q;

    logic [SHW-1:0]    step;
    logic [SHW-1:0]    rem_d;
    logic [XLEN-1:0]   work_d;
    logic [2*XLEN-1:0] wide;
    logic              left;

    // Only the low SHW bits of the shift amount are architecturally meaningful.
    logic unused_shamt;
    assign unused_shamt = ^bus.req_shamt[7:SHW];

    // The working register is extended by one word of fill bits (or a copy of
    // itself for rotates); a single shift of the double word then yields the
    // correctly filled XLEN-bit result.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        left   = 1'b0;
        wide   = '0;
        step   = ({1'b0, rem_q} < STEP_W) ? rem_q : STEP_W[SHW-1:0];
        rem_d  = rem_q - step;
        case (op_q)
            OP_SLL:  begin left = 1'b1; wide = {work_q, {XLEN{1'b0}}}; end
            OP_SLO:  begin left = 1'b1; wide = {work_q, {XLEN{1'b1}}}; end
            OP_ROL:  begin left = 1'b1; wide = {work_q, work_q};       end
            OP_SRL:  wide = {{XLEN{1'b0}}, work_q};
            OP_SRA:  wide = {{XLEN{work_q[XLEN-1]}}, work_q};
            OP_SRO:  wide = {{XLEN{1'b1}}, work_q};
            OP_ROR:  wide = {work_q, work_q};
            default: wide = '0;
        endcase
        work_d = left ? XLEN'((wide << step) >> XLEN) : XLEN'(wide >> step);
    end

    // SRA keeps refilling from the current MSB, which never changes while
    // shifting right arithmetically, so it always equals the original bit.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!g_resetn) begin
            state_q     <= IDLE;
            op_q        <= OP_SLL;
            work_q      <= '0;
            rem_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= op_e'(bus.req_op);
                        work_q  <= bus.req_rs1;
                        rem_q   <= bus.req_shamt[SHW-1:0];
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (op_q == OP_ILL) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        work_q <= work_d;
                        rem_q  <= rem_d;
                        if (rem_d == '0) begin
                            rsp_data_q  <= work_d;
                            rsp_err_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !flush && g_resetn;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_bitmanip_iter_shifter.sv
// Scoreboard bench for bitmanip_iter_shifter: one 32-bit STEP=4 unit for directed
// cases plus two 64-bit units (STEP=1 and STEP=64) swept over all ops.
module tb_bitmanip_iter_shifter;
    localparam int NCFG = 3;
    localparam int CFG_X [NCFG] = '{32, 64, 64};
    localparam int CFG_S [NCFG] = '{4, 1, 64};

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_mis = 0;

    always #5 g_clk = ~g_clk;
    always @(posedge g_clk) cyc <= cyc + 1;

    logic        d_valid  [NCFG];
    logic [2:0]  d_op     [NCFG];
    logic [63:0] d_rs1    [NCFG];
    logic [7:0]  d_shamt  [NCFG];
    logic        d_rready [NCFG];
    logic        d_flush  [NCFG];

    logic        o_reqready [NCFG];
    logic        o_rvalid   [NCFG];
    logic [63:0] o_data     [NCFG];
    logic        o_err      [NCFG];
    logic        o_busy     [NCFG];

    exp_t exp_q [NCFG][$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_model(input int xl, input logic [2:0] op,
                                              input logic [63:0] rs1, input logic [7:0] sh8,
                                              output logic err);
        logic [63:0]        m;
        logic [63:0]        a;
        logic signed [63:0] sa;
        logic [63:0]        r;
        int                 sh;
        m   = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        sh  = int'(sh8) & (xl - 1);
        a   = rs1 & m;
        sa  = (xl == 32) ? {{32{a[31]}}, a[31:0]} : a;
        err = 1'b0;
        case (op)
            3'b000:  r = a << sh;
            3'b001:  r = a >> sh;
            3'b010:  r = sa >>> sh;
            3'b011:  r = ~((~a) << sh);
            3'b100:  r = ~(((~a) & m) >> sh);
            3'b101:  r = (a << sh) | (a >> (xl - sh));
            3'b110:  r = (a >> sh) | (a << (xl - sh));
            default: begin r = '0; err = 1'b1; end
        endcase
        return r & m;
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int X = CFG_X[gi];
        localparam int S = CFG_S[gi];

        bitmanip_iter_shifter_if #(.XLEN(X)) bus ();
        logic busy_w;

        assign bus.req_valid  = d_valid[gi];
        assign bus.req_op     = d_op[gi];
        assign bus.req_rs1    = d_rs1[gi][X-1:0];
        assign bus.req_shamt  = d_shamt[gi];
        assign bus.rsp_ready  = d_rready[gi];
        assign o_reqready[gi] = bus.req_ready;
        assign o_rvalid[gi]   = bus.rsp_valid;
        assign o_data[gi]     = 64'(bus.rsp_data);
        assign o_err[gi]      = bus.rsp_err;
        assign o_busy[gi]     = busy_w;

        bitmanip_iter_shifter #(.XLEN(X), .STEP(S)) u_dut (
            .g_clk    (g_clk),
            .g_resetn (g_resetn),
            .flush    (d_flush[gi]),
            .busy     (busy_w),
            .bus      (bus)
        );

        // Monitor: timestamps accepts and first rsp_valid, scores each handshake.
        initial begin
            int   acc_cyc;
            int   first_cyc;
            logic prev_valid;
            exp_t e;
            acc_cyc    = 0;
            first_cyc  = 0;
            prev_valid = 1'b0;
            forever begin
                @(negedge g_clk);
                if (!g_resetn) begin
                    prev_valid = 1'b0;
                end else begin
                    if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
                    if (bus.rsp_valid && !prev_valid) first_cyc = cyc;
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        if (exp_q[gi].size() == 0) begin
                            check($sformatf("c%0d_unexpected_rsp", gi), 64'(bus.rsp_valid), 64'd0);
                        end else begin
                            e = exp_q[gi].pop_front();
                            check($sformatf("c%0d_data", gi), o_data[gi], e.data);
                            check($sformatf("c%0d_err", gi), 64'(bus.rsp_err), 64'(e.err));
                            check($sformatf("c%0d_latency", gi), 64'(first_cyc - acc_cyc), 64'(e.lat));
                        end
                    end
                    prev_valid = bus.rsp_valid;
                end
            end
        end
    end

    // Drive one request (caller is just past a rising edge); returns just past the accept edge.
    task automatic issue(input int k, input logic [2:0] op, input logic [63:0] rs1,
                         input logic [7:0] sh, input bit push, output int waited);
        exp_t e;
        logic err;
        int   shv;
        if (push) begin
            e.data = ref_model(CFG_X[k], op, rs1, sh, err);
            e.err  = err;
            shv    = int'(sh) & (CFG_X[k] - 1);
            e.lat  = (op == 3'b111) ? 2 : 1 + ((shv == 0) ? 1 : (shv + CFG_S[k] - 1) / CFG_S[k]);
            exp_q[k].push_back(e);
        end
        d_op[k]    = op;
        d_rs1[k]   = rs1;
        d_shamt[k] = sh;
        d_valid[k] = 1'b1;
        waited     = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge g_clk);
            if (o_reqready[k]) break;
            waited++;
        end
        if (waited >= 200) check("accept_timeout", 64'(o_reqready[k]), 64'd1);
        @(posedge g_clk);
        #1;
        d_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k);
        int n;
        n = 0;
        while (exp_q[k].size() != 0 && n < 200) begin
            @(negedge g_clk);
            n++;
        end
        if (exp_q[k].size() != 0) begin
            check("rsp_timeout", 64'(exp_q[k].size()), 64'd0);
            exp_q[k].delete();
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic run(input int k, input logic [2:0] op, input logic [63:0] rs1, input logic [7:0] sh);
        int w;
        issue(k, op, rs1, sh, 1'b1, w);
        wait_rsp(k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [63:0] bp_exp;
        logic        bp_err;
        logic [7:0]  sh_tab [6];
        logic [63:0] rs_tab [3];

        for (int k = 0; k < NCFG; k++) begin
            d_valid[k]  = 1'b0;
            d_op[k]     = 3'b000;
            d_rs1[k]    = '0;
            d_shamt[k]  = '0;
            d_rready[k] = 1'b1;
            d_flush[k]  = 1'b0;
        end

        #12;
        check("reset_req_ready", 64'(o_reqready[0]), 64'd0);
        check("reset_rsp_valid", 64'(o_rvalid[0]), 64'd0);
        check("reset_busy", 64'(o_busy[0]), 64'd0);
        check("reset_rsp_data", o_data[0], 64'd0);
        check("reset_rsp_err", 64'(o_err[0]), 64'd0);
        #10 g_resetn = 1'b1;
        @(posedge g_clk);
        #1;

        // Directed 32-bit cases
        run(0, 3'b011, 64'h0000_0001, 8'd4);
        run(0, 3'b100, 64'h8000_0000, 8'd31);
        run(0, 3'b010, 64'h8000_0000, 8'd4);
        run(0, 3'b110, 64'h1234_5678, 8'd8);
        run(0, 3'b101, 64'h1234_5678, 8'h28);
        run(0, 3'b000, 64'hCAFE_F00D, 8'd0);
        run(0, 3'b111, 64'hDEAD_BEEF, 8'd5);
        run(0, 3'b001, 64'hF0F0_1234, 8'd13);
        run(0, 3'b011, 64'h0000_00F0, 8'hFF);
        for (int i = 0; i < 7; i++) run(0, 3'(i), 64'($urandom), 8'($urandom));

        // Backpressure: result held in DONE, then a request is accepted right after the handshake
        d_rready[0] = 1'b0;
        bp_exp = ref_model(32, 3'b110, 64'hA5A5_0FF0, 8'd9, bp_err);
        issue(0, 3'b110, 64'hA5A5_0FF0, 8'd9, 1'b1, w);
        for (int i = 0; i < 20; i++) begin
            @(negedge g_clk);
            if (o_rvalid[0]) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge g_clk);
            check("bp_rsp_valid", 64'(o_rvalid[0]), 64'd1);
            check("bp_rsp_data", o_data[0], bp_exp);
            check("bp_rsp_err", 64'(o_err[0]), 64'(bp_err));
            check("bp_req_ready", 64'(o_reqready[0]), 64'd0);
        end
        @(posedge g_clk);
        #1;
        d_rready[0] = 1'b1;
        @(posedge g_clk);
        #1;
        issue(0, 3'b011, 64'h0000_1000, 8'd3, 1'b1, w);
        check("accept_after_handshake_wait", 64'(w), 64'd0);
        wait_rsp(0);

        // Flush in cycle 3 of a 20-position SLL
        issue(0, 3'b000, 64'h0000_0F0F, 8'd20, 1'b0, w);
        @(posedge g_clk);
        #1;
        d_flush[0] = 1'b1;
        @(posedge g_clk);
        #1;
        d_flush[0] = 1'b0;
        @(negedge g_clk);
        check("flush_busy", 64'(o_busy[0]), 64'd0);
        check("flush_req_ready", 64'(o_reqready[0]), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge g_clk);
            check("flush_no_rsp", 64'(o_rvalid[0]), 64'd0);
        end

        // Flush while a request is offered in IDLE: not accepted
        @(posedge g_clk);
        #1;
        d_flush[0] = 1'b1;
        d_valid[0] = 1'b1;
        @(negedge g_clk);
        check("flush_idle_req_ready", 64'(o_reqready[0]), 64'd0);
        @(posedge g_clk);
        #1;
        d_flush[0] = 1'b0;
        d_valid[0] = 1'b0;
        @(negedge g_clk);
        check("flush_idle_not_busy", 64'(o_busy[0]), 64'd0);
        @(posedge g_clk);
        #1;

        // Asynchronous reset mid-BUSY
        issue(0, 3'b100, 64'h0000_0001, 8'd31, 1'b0, w);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(o_rvalid[0]), 64'd0);
        check("rst_busy", 64'(o_busy[0]), 64'd0);
        check("rst_req_ready", 64'(o_reqready[0]), 64'd0);
        check("rst_rsp_data", o_data[0], 64'd0);
        check("rst_rsp_err", 64'(o_err[0]), 64'd0);
        #2 g_resetn = 1'b1;
        @(posedge g_clk);
        #1;
        run(0, 3'b001, 64'h8000_0001, 8'd1);

        // 64-bit sweeps, STEP=1 and STEP=64
        sh_tab = '{8'd0, 8'd1, 8'd7, 8'd37, 8'd63, 8'hC5};
        rs_tab = '{64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF, 64'h7FF0_0000_0000_F00F};
        for (int k = 1; k < NCFG; k++) begin
            for (int op = 0; op < 8; op++) begin
                for (int s = 0; s < 6; s++) begin
                    run(k, 3'(op), rs_tab[(op + s) % 3], sh_tab[s]);
                end
            end
        end

        repeat (3) @(posedge g_clk);
        for (int k = 0; k < NCFG; k++) check($sformatf("c%0d_queue_empty", k), 64'(exp_q[k].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
